// File: rtl/core_wb_ctrl_pkg.sv
// Shared widths, write-back entry payload and drain FSM encoding for the
// register-array write-back controller.
package core_wb_ctrl_pkg;

  localparam int unsigned XLEN     = 32;
  localparam int unsigned AW       = 5;
  localparam int unsigned WB_DEPTH = 4;

  typedef struct packed {
    logic [AW-1:0]   rd;
    logic [XLEN-1:0] data;
  } wb_entry_t;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_WRITE = 1'b1
  } wb_state_e;

endpackage

// File: rtl/core_wb_ctrl_if.sv
// Result intake, register-array write port and hazard query signals of the
// write-back controller.
interface core_wb_ctrl_if;
  import core_wb_ctrl_pkg::*;

  logic            alu_valid;
  logic            alu_ready;
  logic [AW-1:0]   alu_rd;
  logic [XLEN-1:0] alu_data;
  logic            lsu_valid;
  logic            lsu_ready;
  logic [AW-1:0]   lsu_rd;
  logic [XLEN-1:0] lsu_data;
  logic            rf_wen;
  logic [AW-1:0]   rf_rd_addr;
  logic [XLEN-1:0] rf_rd_din;
  logic            rf_done;
  logic [AW-1:0]   rs1_addr;
  logic [AW-1:0]   rs2_addr;
  logic            rs1_pend;
  logic            rs2_pend;
  logic [XLEN-1:0] rs1_fwd;
  logic [XLEN-1:0] rs2_fwd;
  logic            busy;

  modport master (
    output alu_valid, alu_rd, alu_data, lsu_valid, lsu_rd, lsu_data,
           rf_done, rs1_addr, rs2_addr,
    input  alu_ready, lsu_ready, rf_wen, rf_rd_addr, rf_rd_din,
           rs1_pend, rs2_pend, rs1_fwd, rs2_fwd, busy
  );

  modport slave (
    input  alu_valid, alu_rd, alu_data, lsu_valid, lsu_rd, lsu_data,
           rf_done, rs1_addr, rs2_addr,
    output alu_ready, lsu_ready, rf_wen, rf_rd_addr, rf_rd_din,
           rs1_pend, rs2_pend, rs1_fwd, rs2_fwd, busy
  );

endinterface

// File: rtl/core_wb_fifo.sv
// In-order write-back queue: storage, wrap-around pointers, occupancy count
// and a youngest-match scan over occupied entries for two query addresses.
module core_wb_fifo
  import core_wb_ctrl_pkg::*;
#(
  parameter int unsigned DEPTH = WB_DEPTH
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      push,
  input  wb_entry_t                 push_entry,
  input  logic                      pop,
  output wb_entry_t                 head_entry,
  output wb_entry_t                 nxt_entry,
  output logic [$clog2(DEPTH):0]    count,
  output logic                      full,
  output logic                      empty,
  input  logic [1:0][AW-1:0]        q_addr,
  output logic [1:0]                q_hit,
  output logic [1:0][XLEN-1:0]      q_data
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  wb_entry_t        mem_q [DEPTH];
  wb_entry_t        mem_d [DEPTH];
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             full_q, full_d;
  logic [PTR_W-1:0] nxt_ptr;
  logic [PTR_W-1:0] scan_idx;

  always_comb begin
    mem_d    = mem_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    cnt_d    = cnt_q;
    if (push) begin
      mem_d[wr_ptr_q] = push_entry;
      wr_ptr_d        = wr_ptr_q + PTR_W'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    case ({push, pop})
      2'b10:   cnt_d = cnt_q + CNT_W'(1);
      2'b01:   cnt_d = cnt_q - CNT_W'(1);
      default: cnt_d = cnt_q;
    endcase
    full_d = (cnt_d == CNT_W'(DEPTH));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      cnt_q    <= '0;
      full_q   <= 1'b0;
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      cnt_q    <= cnt_d;
      full_q   <= full_d;
      mem_q    <= mem_d;
    end
  end

  assign nxt_ptr    = rd_ptr_q + PTR_W'(1);
  assign head_entry = mem_q[rd_ptr_q];
  assign nxt_entry  = mem_q[nxt_ptr];
  assign count      = cnt_q;
  assign full       = full_q;
  assign empty      = (cnt_q == '0);

  // Walk oldest to youngest so the last hit left standing is the youngest.
  always_comb begin
    q_hit    = '0;
    q_data   = '0;
    scan_idx = '0;
    for (int q = 0; q < 2; q++) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        scan_idx = rd_ptr_q + PTR_W'(i);
        if ((CNT_W'(i) < cnt_q) && (q_addr[q] != '0) &&
            (mem_q[scan_idx].rd == q_addr[q])) begin
          q_hit[q]  = 1'b1;
          q_data[q] = mem_q[scan_idx].data;
        end
      end
    end
  end

endmodule

// File: rtl/core_wb_ctrl.sv
// Write-back controller: arbitrates ALU/LSU results into the queue, drains it
// one register-array write at a time and reports pending/forward status.
module core_wb_ctrl
  import core_wb_ctrl_pkg::*;
#(
  parameter int unsigned DEPTH = WB_DEPTH
) (
  input  logic           clk,
  input  logic           rst,
  core_wb_ctrl_if.slave  wb
);

  localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

  logic                 fifo_full;
  logic                 fifo_empty;
  logic [CNT_W-1:0]     fifo_count;
  wb_entry_t            head_entry;
  wb_entry_t            nxt_entry;
  wb_entry_t            push_entry;
  logic                 push;
  logic                 pop;
  logic                 lsu_acc;
  logic                 alu_acc;
  logic [1:0][AW-1:0]   q_addr;
  logic [1:0]           q_hit;
  logic [1:0][XLEN-1:0] q_data;

  wb_state_e            state_q, state_d;
  logic                 rf_wen_q, rf_wen_d;
  logic [AW-1:0]        rf_addr_q, rf_addr_d;
  logic [XLEN-1:0]      rf_din_q, rf_din_d;

  // LSU wins ties; x0 results complete the handshake but are never queued.
  always_comb begin
    lsu_acc    = wb.lsu_valid && !fifo_full;
    alu_acc    = wb.alu_valid && !fifo_full && !wb.lsu_valid;
    push_entry = lsu_acc ? '{rd: wb.lsu_rd, data: wb.lsu_data}
                         : '{rd: wb.alu_rd, data: wb.alu_data};
    push       = (lsu_acc && (wb.lsu_rd != '0)) || (alu_acc && (wb.alu_rd != '0));
  end

  core_wb_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk        (clk),
    .rst        (rst),
    .push       (push),
    .push_entry (push_entry),
    .pop        (pop),
    .head_entry (head_entry),
    .nxt_entry  (nxt_entry),
    .count      (fifo_count),
    .full       (fifo_full),
    .empty      (fifo_empty),
    .q_addr     (q_addr),
    .q_hit      (q_hit),
    .q_data     (q_data)
  );

  // Drain FSM: the in-flight entry stays in the queue until rf_done pops it.
  always_comb begin
    state_d   = state_q;
    rf_wen_d  = rf_wen_q;
    rf_addr_d = rf_addr_q;
    rf_din_d  = rf_din_q;
    pop       = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (!fifo_empty) begin
          rf_wen_d  = 1'b1;
          rf_addr_d = head_entry.rd;
          rf_din_d  = head_entry.data;
          state_d   = ST_WRITE;
        end
      end
      ST_WRITE: begin
        if (wb.rf_done) begin
          pop = 1'b1;
          if (fifo_count > CNT_W'(1)) begin
            rf_addr_d = nxt_entry.rd;
            rf_din_d  = nxt_entry.data;
          end else begin
            rf_wen_d = 1'b0;
            state_d  = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      rf_wen_q  <= 1'b0;
      rf_addr_q <= '0;
      rf_din_q  <= '0;
    end else begin
      state_q   <= state_d;
      rf_wen_q  <= rf_wen_d;
      rf_addr_q <= rf_addr_d;
      rf_din_q  <= rf_din_d;
    end
  end

  assign q_addr        = {wb.rs2_addr, wb.rs1_addr};
  assign wb.lsu_ready  = !fifo_full;
  assign wb.alu_ready  = !fifo_full && !wb.lsu_valid;
  assign wb.rf_wen     = rf_wen_q;
  assign wb.rf_rd_addr = rf_addr_q;
  assign wb.rf_rd_din  = rf_din_q;
  assign wb.rs1_pend   = q_hit[0];
  assign wb.rs2_pend   = q_hit[1];
  assign wb.rs1_fwd    = q_data[0];
  assign wb.rs2_fwd    = q_data[1];
  assign wb.busy       = (fifo_count != '0);

endmodule

// File: tb/tb_core_wb_ctrl.sv
// Scoreboard bench for core_wb_ctrl: a queue of accepted writes models
// occupancy, ordering and forwarding; a negedge monitor checks the DUT against it.
module tb_core_wb_ctrl;
  import core_wb_ctrl_pkg::*;

  typedef struct {
    logic [AW-1:0]   rd;
    logic [XLEN-1:0] data;
  } exp_t;

  logic clk;
  logic rst;
  logic tie_done;
  logic done_r;

  exp_t          exp_q[$];
  logic [AW-1:0] wr_log[$];
  bit            model_full;
  int            checks;
  int            errors;

  core_wb_ctrl_if wbi();

  core_wb_ctrl #(.DEPTH(WB_DEPTH)) dut (
    .clk (clk),
    .rst (rst),
    .wb  (wbi)
  );

  assign wbi.rf_done = tie_done ? wbi.rf_wen : done_r;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, want, $time);
    end
  endtask

  // Youngest pending value among all queued-or-in-flight writes.
  function automatic void model_query(input logic [AW-1:0] a, output bit p,
                                      output logic [XLEN-1:0] d);
    p = 1'b0;
    d = '0;
    if (a != '0) begin
      foreach (exp_q[i]) begin
        if (exp_q[i].rd == a) begin
          p = 1'b1;
          d = exp_q[i].data;
        end
      end
    end
  endfunction

  // Issue side: record every result the model says is accepted.
  always @(posedge clk) begin
    if (rst) begin
      exp_q.delete();
    end else if (!model_full) begin
      if (wbi.lsu_valid) begin
        if (wbi.lsu_rd != '0) exp_q.push_back('{wbi.lsu_rd, wbi.lsu_data});
      end else if (wbi.alu_valid && (wbi.alu_rd != '0)) begin
        exp_q.push_back('{wbi.alu_rd, wbi.alu_data});
      end
    end
  end

  // Monitor: compare visible state, then retire a write completing at the next edge.
  always @(negedge clk) begin
    bit              lr;
    bit              p;
    logic [XLEN-1:0] f;
    if (rst) begin
      model_full = 1'b0;
    end else begin
      lr = (exp_q.size() < int'(WB_DEPTH));
      chk("lsu_ready", 32'(wbi.lsu_ready), 32'(lr));
      chk("alu_ready", 32'(wbi.alu_ready), 32'(lr && !wbi.lsu_valid));
      chk("busy", 32'(wbi.busy), 32'(exp_q.size() != 0));
      model_query(wbi.rs1_addr, p, f);
      chk("rs1_pend", 32'(wbi.rs1_pend), 32'(p));
      chk("rs1_fwd", wbi.rs1_fwd, f);
      model_query(wbi.rs2_addr, p, f);
      chk("rs2_pend", 32'(wbi.rs2_pend), 32'(p));
      chk("rs2_fwd", wbi.rs2_fwd, f);
      if (exp_q.size() == 0) begin
        chk("rf_wen_when_empty", 32'(wbi.rf_wen), 32'd0);
      end else if (wbi.rf_wen) begin
        chk("rf_rd_addr", 32'(wbi.rf_rd_addr), 32'(exp_q[0].rd));
        chk("rf_rd_din", wbi.rf_rd_din, exp_q[0].data);
        if (wbi.rf_done) begin
          wr_log.push_back(exp_q[0].rd);
          void'(exp_q.pop_front());
        end
      end
      model_full = !lr;
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    wbi.alu_valid = 1'b0;
    wbi.alu_rd    = '0;
    wbi.alu_data  = '0;
    wbi.lsu_valid = 1'b0;
    wbi.lsu_rd    = '0;
    wbi.lsu_data  = '0;
    wbi.rs1_addr  = '0;
    wbi.rs2_addr  = '0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int guard;
    checks     = 0;
    errors     = 0;
    model_full = 1'b0;
    tie_done   = 1'b1;
    done_r     = 1'b0;
    rst        = 1'b1;
    clear_inputs();
    repeat (2) cyc();
    rst = 1'b0;
    cyc();

    // Single write with rf_done tied to rf_wen: two-edge latency, one-cycle pulse.
    wbi.alu_valid = 1'b1; wbi.alu_rd = 5'd3; wbi.alu_data = 32'hDEAD_BEEF;
    wbi.rs1_addr  = 5'd3;
    cyc();
    wbi.alu_valid = 1'b0;
    @(negedge clk);
    chk("single_pend", 32'(wbi.rs1_pend), 32'd1);
    chk("single_lat_edge1", 32'(wbi.rf_wen), 32'd0);
    cyc();
    @(negedge clk);
    chk("single_lat_edge2", 32'(wbi.rf_wen), 32'd1);
    chk("single_addr", 32'(wbi.rf_rd_addr), 32'd3);
    chk("single_data", wbi.rf_rd_din, 32'hDEAD_BEEF);
    cyc();
    @(negedge clk);
    chk("single_pulse_end", 32'(wbi.rf_wen), 32'd0);
    chk("single_pend_clear", 32'(wbi.rs1_pend), 32'd0);
    cyc();

    // Collision: LSU first, ALU stalls one cycle.
    wr_log.delete();
    wbi.lsu_valid = 1'b1; wbi.lsu_rd = 5'd2; wbi.lsu_data = 32'h0000_0222;
    wbi.alu_valid = 1'b1; wbi.alu_rd = 5'd1; wbi.alu_data = 32'h0000_0111;
    @(negedge clk);
    chk("coll_alu_ready", 32'(wbi.alu_ready), 32'd0);
    chk("coll_lsu_ready", 32'(wbi.lsu_ready), 32'd1);
    cyc();
    wbi.lsu_valid = 1'b0;
    cyc();
    wbi.alu_valid = 1'b0;
    repeat (6) cyc();
    chk("coll_nwrites", 32'(wr_log.size()), 32'd2);
    if (wr_log.size() == 2) begin
      chk("coll_first_rd", 32'(wr_log[0]), 32'd2);
      chk("coll_second_rd", 32'(wr_log[1]), 32'd1);
    end

    // Backpressure: fill to DEPTH with the write port stalled.
    tie_done = 1'b0;
    done_r   = 1'b0;
    for (int k = 0; k < int'(WB_DEPTH); k++) begin
      wbi.alu_valid = 1'b1; wbi.alu_rd = 5'(4 + k); wbi.alu_data = $urandom;
      cyc();
    end
    wbi.alu_valid = 1'b0;
    wbi.lsu_valid = 1'b1; wbi.lsu_rd = 5'd9; wbi.lsu_data = 32'h9999_9999;
    @(negedge clk);
    chk("bp_lsu_ready", 32'(wbi.lsu_ready), 32'd0);
    chk("bp_alu_ready", 32'(wbi.alu_ready), 32'd0);
    repeat (2) cyc();
    @(negedge clk);
    chk("bp_hold_addr", 32'(wbi.rf_rd_addr), 32'd4);
    cyc();
    wbi.lsu_valid = 1'b0;
    done_r = 1'b1;
    for (int j = 0; j < int'(WB_DEPTH); j++) begin
      @(negedge clk);
      chk("drain_wen", 32'(wbi.rf_wen), 32'd1);
      chk("drain_addr", 32'(wbi.rf_rd_addr), 32'(4 + j));
      cyc();
    end
    @(negedge clk);
    chk("drain_idle", 32'(wbi.rf_wen), 32'd0);
    cyc();

    // Forwarding picks the youngest of two writes to the same register.
    done_r = 1'b0;
    wbi.alu_valid = 1'b1; wbi.alu_rd = 5'd5; wbi.alu_data = 32'h11;
    cyc();
    wbi.alu_data = 32'h22;
    cyc();
    wbi.alu_valid = 1'b0;
    wbi.rs1_addr = 5'd5;
    wbi.rs2_addr = 5'd0;
    @(negedge clk);
    chk("fwd_rs1_pend", 32'(wbi.rs1_pend), 32'd1);
    chk("fwd_rs1_data", wbi.rs1_fwd, 32'h22);
    chk("fwd_rs2_pend", 32'(wbi.rs2_pend), 32'd0);
    chk("fwd_rs2_data", wbi.rs2_fwd, 32'd0);
    cyc();
    tie_done = 1'b1;
    repeat (6) cyc();

    // x0 results complete the handshake but never write.
    wbi.lsu_valid = 1'b1; wbi.lsu_rd = 5'd0; wbi.lsu_data = 32'h1234;
    @(negedge clk);
    chk("x0_lsu_ready", 32'(wbi.lsu_ready), 32'd1);
    cyc();
    wbi.lsu_valid = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk("x0_busy", 32'(wbi.busy), 32'd0);
      chk("x0_wen", 32'(wbi.rf_wen), 32'd0);
      cyc();
    end

    // Reset in the middle of a stalled write.
    tie_done = 1'b0;
    done_r   = 1'b0;
    wbi.alu_valid = 1'b1; wbi.alu_rd = 5'd7; wbi.alu_data = 32'h7777_0000;
    cyc();
    wbi.alu_valid = 1'b0;
    cyc();
    @(negedge clk);
    chk("rst_pre_wen", 32'(wbi.rf_wen), 32'd1);
    cyc();
    rst = 1'b1;
    repeat (2) cyc();
    rst = 1'b0;
    @(negedge clk);
    chk("rst_wen", 32'(wbi.rf_wen), 32'd0);
    chk("rst_busy", 32'(wbi.busy), 32'd0);
    chk("rst_lsu_ready", 32'(wbi.lsu_ready), 32'd1);
    chk("rst_alu_ready", 32'(wbi.alu_ready), 32'd1);
    cyc();

    // Randomised traffic with random write-port stalls and hazard queries.
    for (int n = 0; n < 600; n++) begin
      wbi.lsu_valid = ($urandom_range(0, 3) == 0);
      wbi.lsu_rd    = 5'($urandom_range(0, 7));
      wbi.lsu_data  = $urandom;
      wbi.alu_valid = ($urandom_range(0, 1) == 1);
      wbi.alu_rd    = 5'($urandom_range(0, 7));
      wbi.alu_data  = $urandom;
      wbi.rs1_addr  = 5'($urandom_range(0, 7));
      wbi.rs2_addr  = 5'($urandom_range(0, 7));
      done_r        = ($urandom_range(0, 2) != 0);
      cyc();
    end
    clear_inputs();
    done_r = 1'b1;
    guard  = 0;
    while (wbi.busy && guard < 40) begin
      cyc();
      guard++;
    end
    @(negedge clk);
    chk("final_busy", 32'(wbi.busy), 32'd0);
    chk("final_model_empty", 32'(exp_q.size()), 32'd0);
    chk("final_wen", 32'(wbi.rf_wen), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
